dice_display_driver: RTL and testbench
======================================

// Module: dice_display_driver
// PURPOSE
//  Downstream stage of the dice roller and the I2C brightness register. Takes the rolled
//  ones/tens digits and a 7-bit duty value, and time-multiplexes two 7-segment digits.
//  Output polarity is set by pin config. Output is PWM-dimmed at duty_i/128.
//  Drives uo_out (segments) and uio_out[3]/[4] (commons) in tt_um_sanojn_ttrpgdice_ihp.
// PARAMETERS
//  TICK_DIV  64  clk cycles per PWM step (>=2); PWM frame = 128 steps.
// PORTS
//  clk             in   1  system clock
//  rst_n           in   1  asynchronous, active-low reset
//  digit1_i        in   4  ones digit, 0-9 shown, 10-15 blank (15 = empty)
//  digit10_i       in   4  tens digit, same coding
//  duty_i          in   7  brightness: lit steps per 128-step frame (I2C reg 8 [6:0])
//  blank_lz_i      in   1  1 = tens digit 0 is shown blank
//  seg_act_high_i  in   1  segment polarity (uio_in[6]); 1 = lit segment drives 1
//  com_act_high_i  in   1  common polarity (uio_in[7]); active common = this level
//  seg_o           out  8  segments {dp,g,f,e,d,c,b,a}; dp is always unlit
//  com1_o          out  1  ones-digit common
//  com10_o         out  1  tens-digit common
//  com_oe_o        out  2  {com10,com1} output enables; constant 2'b11 out of reset
//  frame_o         out  1  1-cycle pulse at each frame start (debug/test hook)
// BEHAVIOUR
//  Reset is asynchronous and active-low. All registers clear: prescaler, step, phase=ONES,
//   shadow digits=15, shadow duty=0, lit vector=0, com_act=2'b00, frame_o=0.
//  Outputs are combinational XOR of registered state with the polarity inputs. Between
//   reset and the first lit step, outputs are therefore "all dark":
//   seg_o = seg_act_high_i ? 8'h00 : 8'hFF, and each com = ~com_act_high_i.
//  Prescaler counts 0..TICK_DIV-1. tick = (prescaler==TICK_DIV-1).
//  On each tick, step (7-bit) increments and wraps 127->0.
//  Phase FSM has two states, ONES and TENS. The phase toggles on the tick where step
//   wraps 127->0. Each phase lasts exactly one 128-step frame. The FSM always
//   alternates, including when a digit is blank, so brightness stays constant.
//  Shadow load happens on the same tick as the wrap. It captures digit1_i, digit10_i
//   and duty_i. Input changes mid-frame never alter the frame in progress.
//   frame_o pulses in that same cycle.
//  Lit condition for the current step: step < duty_sh.
//   duty 0 -> never lit.
//   duty 127 -> lit 127/128 steps; step 127 is always dark and acts as ghosting guard.
//  Registered lit pattern, updated every clk:
//   lit = (lit condition) ? SEG[phase digit] : 0.
//   com_act = lit condition ? one-hot(phase) : 2'b00.
//  Both commons are never active together.
//  Segment table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 10-15 = 00.
//  Tens digit is forced to blank when blank_lz_i=1 and tens shadow==0.
//  Latency: output reflects step/phase 1 clk after the tick.
//  Polarity input changes take effect combinationally.
//  Reset asserted mid-frame: outputs go dark immediately. The frame restarts in phase
//   ONES after release. Shadows hold 15/0 until the first wrap, ~128*TICK_DIV clks.
// STRUCTURE
//  Shared package dice_display_pkg holds:
//   - PWM_STEPS=128, BLANK_CODE=4'hF, phase encoding (ONES=0, TENS=1)
//   - function seg7_encode(4b)->8b; also used by the bench decoder
//  Sub-module dice_pwm_timebase(TICK_DIV) holds the prescaler and step counter. It
//   outputs tick, step[6:0] and wrap.
//  The top holds shadows, phase FSM, encode and output registers.
// TESTING
//  1 Reset: hold rst_n=0, pol=1/1 -> seg_o=00, com1_o=com10_o=0, com_oe_o=11.
//    Release; for the first frame the display stays dark.
//  2 digit1=4, digit10=2, duty=0x40, pol 1/1:
//    ONES frame -> seg_o=66, com1_o=1 for exactly 64 steps (64*TICK_DIV clks).
//    TENS frame -> seg_o=5B, com10_o=1.
//  3 Duty sweep 0x00/0x01/0x21/0x7F -> lit steps per frame = 0/1/33/127.
//    com1_o and com10_o are never both 1.
//  4 Polarity: seg_act_high=0, com_act_high=0 with digit1=8 -> seg_o=80 when lit, FF dark.
//    Active common=0.
//  5 Change digit1 3->7 at step 50 -> current frame still shows 4F; next ONES frame
//    shows 07.
//    digit10=0 with blank_lz=1 -> TENS frame seg all dark.
//  6 Assert rst_n low at step 90 of TENS -> outputs dark same cycle.
//    After release, first frame_o arrives 128*TICK_DIV clks later; ONES phase next.

Source files
------------

// File: rtl/dice_display_pkg.sv
// Shared constants, phase encoding and 7-segment decoder for the dice display path.
package dice_display_pkg;

  localparam int         PWM_STEPS  = 128;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    PH_ONES = 1'b0,
    PH_TENS = 1'b1
  } phase_e;

  // Active-high segment pattern {dp,g,f,e,d,c,b,a}; codes 10-15 are blank.
  function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/dice_pwm_timebase.sv
// PWM timebase: prescaler divides clk by TICK_DIV, 7-bit step counter spans one frame.
module dice_pwm_timebase
  import dice_display_pkg::*;
#(
  parameter int TICK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [6:0] step_o,
  output logic       wrap_o
);

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]    STEP_MAX  = 7'(PWM_STEPS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    step_q, step_d;

  always_comb begin
    tick_o  = (presc_q == PRESC_MAX);
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    step_d  = tick_o ? step_q + 7'd1 : step_q;
    wrap_o  = tick_o && (step_q == STEP_MAX);
    step_o  = step_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/dice_display_driver.sv
// Two-digit multiplexed, PWM-dimmed 7-segment driver. Each digit owns one full frame;
// digit and duty inputs are shadowed at the frame boundary.
module dice_display_driver
  import dice_display_pkg::*;
#(
  parameter int TICK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit10_i,
  input  logic [6:0] duty_i,
  input  logic       blank_lz_i,
  input  logic       seg_act_high_i,
  input  logic       com_act_high_i,
  output logic [7:0] seg_o,
  output logic       com1_o,
  output logic       com10_o,
  output logic [1:0] com_oe_o,
  output logic       frame_o
);

  logic       tick, wrap;
  logic [6:0] step;

  dice_pwm_timebase #(.TICK_DIV(TICK_DIV)) u_timebase (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick),
    .step_o (step),
    .wrap_o (wrap)
  );

  phase_e     phase_q, phase_d;
  logic       started_q;
  logic [3:0] d1_sh_q, d10_sh_q;
  logic [6:0] duty_sh_q;
  logic [7:0] lit_q, lit_d;
  logic [1:0] com_q, com_d;
  logic       frame_q;
  logic       frame_start;
  logic       lit_on;
  logic [3:0] cur_digit;

  always_comb begin
    frame_start = tick & wrap;
    phase_d     = phase_q;
    // The dark frame right after reset is a ONES frame; the first loaded frame is ONES too.
    if (frame_start && started_q)
      phase_d = (phase_q == PH_ONES) ? PH_TENS : PH_ONES;
  end

  always_comb begin
    lit_on = (step < duty_sh_q);
    if (phase_q == PH_ONES)
      cur_digit = d1_sh_q;
    else if (blank_lz_i && (d10_sh_q == 4'd0))
      cur_digit = BLANK_CODE;
    else
      cur_digit = d10_sh_q;
    lit_d = lit_on ? seg7_encode(cur_digit) : 8'h00;
    com_d = 2'b00;
    if (lit_on)
      com_d = (phase_q == PH_ONES) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_ONES;
      started_q <= 1'b0;
      d1_sh_q   <= BLANK_CODE;
      d10_sh_q  <= BLANK_CODE;
      duty_sh_q <= 7'd0;
      lit_q     <= 8'h00;
      com_q     <= 2'b00;
      frame_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      lit_q   <= lit_d;
      com_q   <= com_d;
      frame_q <= frame_start;
      if (frame_start) begin
        started_q <= 1'b1;
        d1_sh_q   <= digit1_i;
        d10_sh_q  <= digit10_i;
        duty_sh_q <= duty_i;
      end
    end
  end

  assign seg_o    = lit_q ^ {8{~seg_act_high_i}};
  assign com1_o   = com_q[0] ^ ~com_act_high_i;
  assign com10_o  = com_q[1] ^ ~com_act_high_i;
  assign com_oe_o = 2'b11;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_dice_display_driver.sv
// Directed bench for dice_display_driver: vector table over whole frames plus reset,
// mid-frame digit change and mid-frame reset sequences.
module tb_dice_display_driver;

  localparam int TD    = 4;
  localparam int FRAME = 128 * TD;

  logic       clk, rst_n;
  logic [3:0] digit1, digit10;
  logic [6:0] duty;
  logic       blank_lz, seg_pol, com_pol;
  logic [7:0] seg_o;
  logic       com1_o, com10_o, frame_o;
  logic [1:0] com_oe_o;

  dice_display_driver #(.TICK_DIV(TD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digit1_i       (digit1),
    .digit10_i      (digit10),
    .duty_i         (duty),
    .blank_lz_i     (blank_lz),
    .seg_act_high_i (seg_pol),
    .com_act_high_i (com_pol),
    .seg_o          (seg_o),
    .com1_o         (com1_o),
    .com10_o        (com10_o),
    .com_oe_o       (com_oe_o),
    .frame_o        (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame pulses seen since reset; even count at a pulse means a ONES frame starts.
  int fcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fcnt <= 0;
    else if (frame_o) fcnt <= fcnt + 1;
  end

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d10;
    logic [6:0] duty;
    logic       blz;
    logic       spol;
    logic       cpol;
    logic [7:0] on1;
    logic [7:0] on10;
    logic [7:0] off;
    int         lit;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    bit ok = 1'b0;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      if (frame_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_phase(input bit want_tens);
    @(negedge clk);
    wait_frame();
    if (fcnt[0] != want_tens) begin
      @(negedge clk);
      wait_frame();
    end
  endtask

  // Call at the negedge where frame_o is high; returns at the next frame pulse.
  task automatic measure(input string tag, input logic [7:0] on1, input logic [7:0] on10,
                         input logic [7:0] off, input logic cpol, input int exp_lit,
                         input int chg_at, input logic [3:0] chg_val);
    bit         tens = fcnt[0];
    int         n_act = 0, n_other = 0, n_bad = 0;
    logic       a1, a10;
    logic [7:0] exp_seg;
    for (int m = 0; m < FRAME; m++) begin
      if (m == chg_at) digit1 = chg_val;
      a1  = (com1_o === cpol);
      a10 = (com10_o === cpol);
      if (tens ? a10 : a1) begin
        n_act++;
        exp_seg = tens ? on10 : on1;
      end else begin
        exp_seg = off;
      end
      if (tens ? a1 : a10) n_other++;
      if (seg_o !== exp_seg) n_bad++;
      @(negedge clk);
    end
    chk({tag, "_lit"},       32'(n_act),   32'(exp_lit));
    chk({tag, "_other_com"}, 32'(n_other), 32'd0);
    chk({tag, "_seg"},       32'(n_bad),   32'd0);
  endtask

  task automatic count_to_frame(input string tag);
    int n = 0, dark_bad = 0;
    while (frame_o !== 1'b1 && n < 2 * FRAME) begin
      if (com1_o === com_pol || com10_o === com_pol) dark_bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_dark"},    32'(dark_bad), 32'd0);
    chk({tag, "_latency"}, 32'(n),        32'(FRAME));
  endtask

  initial begin
    vecs[0] = '{4'd4,  4'd2,  7'h40, 1'b0, 1'b1, 1'b1, 8'h66, 8'h5B, 8'h00, 64 * TD};
    vecs[1] = '{4'd9,  4'd1,  7'h00, 1'b0, 1'b1, 1'b1, 8'h6F, 8'h06, 8'h00, 0};
    vecs[2] = '{4'd5,  4'd3,  7'h01, 1'b0, 1'b1, 1'b1, 8'h6D, 8'h4F, 8'h00, 1 * TD};
    vecs[3] = '{4'd0,  4'd6,  7'h21, 1'b0, 1'b1, 1'b1, 8'h3F, 8'h7D, 8'h00, 33 * TD};
    vecs[4] = '{4'd7,  4'd8,  7'h7F, 1'b0, 1'b1, 1'b1, 8'h07, 8'h7F, 8'h00, 127 * TD};
    vecs[5] = '{4'd8,  4'd0,  7'h10, 1'b0, 1'b0, 1'b0, 8'h80, 8'hC0, 8'hFF, 16 * TD};
    vecs[6] = '{4'd1,  4'd0,  7'h20, 1'b1, 1'b1, 1'b1, 8'h06, 8'h00, 8'h00, 32 * TD};
    vecs[7] = '{4'd12, 4'd15, 7'h08, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8 * TD};

    rst_n    = 1'b0;
    digit1   = 4'd4;
    digit10  = 4'd2;
    duty     = 7'h40;
    blank_lz = 1'b0;
    seg_pol  = 1'b1;
    com_pol  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg",    32'(seg_o),    32'h00);
    chk("rst_com1",   32'(com1_o),   32'd0);
    chk("rst_com10",  32'(com10_o),  32'd0);
    chk("rst_com_oe", 32'(com_oe_o), 32'h3);
    chk("rst_frame",  32'(frame_o),  32'd0);
    seg_pol = 1'b0;
    #1;
    chk("rst_seg_pol0", 32'(seg_o), 32'hFF);
    seg_pol = 1'b1;
    @(negedge clk);

    rst_n = 1'b1;
    count_to_frame("first_frame");

    for (int i = 0; i < 8; i++) begin
      digit1   = vecs[i].d1;
      digit10  = vecs[i].d10;
      duty     = vecs[i].duty;
      blank_lz = vecs[i].blz;
      seg_pol  = vecs[i].spol;
      com_pol  = vecs[i].cpol;
      @(negedge clk);
      wait_frame();
      measure($sformatf("v%0d_a", i), vecs[i].on1, vecs[i].on10, vecs[i].off,
              vecs[i].cpol, vecs[i].lit, -1, 4'd0);
      measure($sformatf("v%0d_b", i), vecs[i].on1, vecs[i].on10, vecs[i].off,
              vecs[i].cpol, vecs[i].lit, -1, 4'd0);
    end

    // Digit change mid-frame only shows up in the next ONES frame.
    digit1 = 4'd3; digit10 = 4'd2; duty = 7'h40;
    blank_lz = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;
    wait_phase(1'b0);
    measure("chg_cur",  8'h4F, 8'h5B, 8'h00, 1'b1, 64 * TD, 50 * TD, 4'd7);
    measure("chg_tens", 8'h07, 8'h5B, 8'h00, 1'b1, 64 * TD, -1, 4'd0);
    measure("chg_next", 8'h07, 8'h5B, 8'h00, 1'b1, 64 * TD, -1, 4'd0);

    // Reset at step 90 of a TENS frame.
    digit1 = 4'd5; digit10 = 4'd9; duty = 7'h7F;
    wait_phase(1'b0);
    wait_phase(1'b1);
    repeat (90 * TD + 2) @(negedge clk);
    chk("pre_rst_com10", 32'(com10_o), 32'd1);
    chk("pre_rst_seg",   32'(seg_o),   32'h6F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",   32'(seg_o),   32'h00);
    chk("mid_rst_com1",  32'(com1_o),  32'd0);
    chk("mid_rst_com10", 32'(com10_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_frame("after_rst");
    measure("after_rst_ones", 8'h6D, 8'h6F, 8'h00, 1'b1, 127 * TD, -1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
